// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM-side inputs, decode operand indices and register-file/bypass outputs of the WB stage.
interface writeback_stage_if;
    logic        mem_valid, mem_regwrite, mem_op2, mem_memtoreg;
    logic [3:0]  mem_rd1, mem_rd2;
    logic [15:0] mem_result1, mem_result2, mem_load_data;
    logic        stall, flush;
    logic [3:0]  id_rs1, id_rs2;
    logic [3:0]  WriteReg1, WriteReg2;
    logic [15:0] WriteData1, WriteData2;
    logic        RegWrite, WriteOP2, fwd1_hit, fwd2_hit, wb_conflict;
    logic [15:0] fwd1_data, fwd2_data, retire_count;
    modport master (
        output mem_valid, mem_regwrite, mem_op2, mem_memtoreg, mem_rd1, mem_rd2,
               mem_result1, mem_result2, mem_load_data, stall, flush, id_rs1, id_rs2,
        input  WriteReg1, WriteReg2, WriteData1, WriteData2, RegWrite, WriteOP2,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, wb_conflict, retire_count
    );
    modport slave (
        input  mem_valid, mem_regwrite, mem_op2, mem_memtoreg, mem_rd1, mem_rd2,
               mem_result1, mem_result2, mem_load_data, stall, flush, id_rs1, id_rs2,
        output WriteReg1, WriteReg2, WriteData1, WriteData2, RegWrite, WriteOP2,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, wb_conflict, retire_count
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register driving the dual-port register file, WB->ID bypass and retire counter.
module writeback_stage (
    input logic              clk,
    input logic              rst,
    writeback_stage_if.slave wb
);
    logic        wb_valid, regwrite_q, op2_q, conflict_q;
    logic [3:0]  rd1_q, rd2_q;
    logic [15:0] data1_q, data2_q, retire_q;
    logic        dup, h1a, h1b, h2a, h2b;

    // A dual write to one index keeps only port 1
    assign dup = wb.mem_regwrite & (wb.mem_rd1 == wb.mem_rd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid   <= 1'b0;
            regwrite_q <= 1'b0;
            op2_q      <= 1'b0;
            conflict_q <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            retire_q   <= '0;
        end else begin
            if (wb_valid && !wb.stall) retire_q <= retire_q + 16'd1;
            if (wb.flush) begin
                wb_valid   <= 1'b0;
                regwrite_q <= 1'b0;
                op2_q      <= 1'b0;
                conflict_q <= 1'b0;
            end else if (wb.stall) begin
                conflict_q <= 1'b0;
            end else begin
                wb_valid   <= wb.mem_valid;
                regwrite_q <= wb.mem_valid & wb.mem_regwrite;
                op2_q      <= wb.mem_valid & wb.mem_op2 & ~dup;
                conflict_q <= wb.mem_valid & wb.mem_op2 & dup;
                rd1_q      <= wb.mem_rd1;
                rd2_q      <= wb.mem_rd2;
                data1_q    <= wb.mem_memtoreg ? wb.mem_load_data : wb.mem_result1;
                data2_q    <= wb.mem_result2;
            end
        end
    end

    assign wb.RegWrite     = regwrite_q;
    assign wb.WriteOP2     = op2_q;
    assign wb.WriteReg1    = rd1_q;
    assign wb.WriteReg2    = rd2_q;
    assign wb.WriteData1   = data1_q;
    assign wb.WriteData2   = data2_q;
    assign wb.wb_conflict  = conflict_q;
    assign wb.retire_count = retire_q;

    always_comb begin
        h1a          = regwrite_q & (rd1_q == wb.id_rs1);
        h1b          = op2_q & (rd2_q == wb.id_rs1);
        h2a          = regwrite_q & (rd1_q == wb.id_rs2);
        h2b          = op2_q & (rd2_q == wb.id_rs2);
        wb.fwd1_hit  = h1a | h1b;
        wb.fwd2_hit  = h2a | h2b;
        wb.fwd1_data = h1a ? data1_q : (h1b ? data2_q : 16'd0);
        wb.fwd2_data = h2a ? data1_q : (h2b ? data2_q : 16'd0);
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard-driven checks of WB register, bypass, stall/flush, async reset and retire counter.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct packed {
        logic        rw, op2;
        logic [3:0]  rd1, rd2;
        logic [15:0] d1, d2;
        logic        cf;
    } exp_t;

    exp_t q[$];
    exp_t e;

    writeback_stage_if bus();
    writeback_stage dut (.clk(clk), .rst(rst), .wb(bus));

    always #5 clk = ~clk;

    function automatic exp_t actual();
        return {bus.RegWrite, bus.WriteOP2, bus.WriteReg1, bus.WriteReg2,
                bus.WriteData1, bus.WriteData2, bus.wb_conflict};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, rw, o2, m2r, input logic [3:0] r1, r2,
                         input logic [15:0] a, b, ld, input bit push);
        exp_t x;
        bus.mem_valid = v; bus.mem_regwrite = rw; bus.mem_op2 = o2; bus.mem_memtoreg = m2r;
        bus.mem_rd1 = r1; bus.mem_rd2 = r2;
        bus.mem_result1 = a; bus.mem_result2 = b; bus.mem_load_data = ld;
        x.rw  = v & rw;
        x.op2 = v & o2 & ~(rw & (r1 == r2));
        x.cf  = v & o2 & rw & (r1 == r2);
        x.rd1 = r1; x.rd2 = r2;
        x.d1  = m2r ? ld : a;
        x.d2  = b;
        if (push) q.push_back(x);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 0, 4'd5, 4'd6, 16'h1111, 16'h2222, 16'h3333, 0);
        tick(); tick();
        n_cmp++;
        if (actual() !== '0) begin n_err++; $display("FAIL reset_wb got %h exp 0", actual()); end
        n_cmp++;
        if ({bus.fwd1_hit, bus.fwd2_hit, bus.fwd1_data, bus.fwd2_data, bus.retire_count} !== '0) begin
            n_err++; $display("FAIL reset_fwd_cnt got %b/%b %h %h %h exp 0", bus.fwd1_hit, bus.fwd2_hit,
                              bus.fwd1_data, bus.fwd2_data, bus.retire_count);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
    endtask

    task automatic test_dual_write();
        drive(1, 1, 1, 0, 4'd15, 4'd10, 16'hFFFF, 16'd2000, 16'h0, 1);
        bus.id_rs1 = 4'd15; bus.id_rs2 = 4'd10;
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e) begin n_err++; $display("FAIL dual_write_wb got %h exp %h", actual(), e); end
        n_cmp++;
        if ({bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data} !== {1'b1, 16'hFFFF, 1'b1, 16'd2000}) begin
            n_err++; $display("FAIL dual_write_fwd got %b %h %b %h exp 1 ffff 1 07d0",
                              bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data);
        end
        n_cmp++;
        if (bus.retire_count !== 16'd0) begin n_err++; $display("FAIL dual_write_cnt0 got %h exp 0", bus.retire_count); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e) begin n_err++; $display("FAIL dual_write_idle got %h exp %h", actual(), e); end
        n_cmp++;
        if (bus.retire_count !== 16'd1) begin n_err++; $display("FAIL dual_write_cnt1 got %h exp 1", bus.retire_count); end
    endtask

    task automatic test_load_select();
        drive(1, 1, 0, 1, 4'd3, 4'd7, 16'h00FF, 16'h0000, 16'h1234, 1);
        bus.id_rs1 = 4'd7; bus.id_rs2 = 4'd3;
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e) begin n_err++; $display("FAIL load_sel_wb got %h exp %h", actual(), e); end
        n_cmp++;
        if ({bus.fwd2_hit, bus.fwd2_data, bus.fwd1_hit, bus.fwd1_data} !== {1'b1, 16'h1234, 1'b0, 16'h0}) begin
            n_err++; $display("FAIL load_sel_fwd got %b %h %b %h exp 1 1234 0 0000",
                              bus.fwd2_hit, bus.fwd2_data, bus.fwd1_hit, bus.fwd1_data);
        end
    endtask

    task automatic test_conflict();
        drive(1, 1, 1, 0, 4'd15, 4'd15, 16'hAAAA, 16'h5555, 16'h0, 1);
        bus.id_rs1 = 4'd15;
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e) begin n_err++; $display("FAIL conflict_wb got %h exp %h", actual(), e); end
        n_cmp++;
        if ({bus.RegWrite, bus.WriteOP2, bus.wb_conflict, bus.fwd1_data} !== {3'b101, 16'hAAAA}) begin
            n_err++; $display("FAIL conflict_flags got %b%b%b %h exp 101 aaaa",
                              bus.RegWrite, bus.WriteOP2, bus.wb_conflict, bus.fwd1_data);
        end
        drive(1, 0, 1, 0, 4'd5, 4'd9, 16'h1111, 16'h2222, 16'h0, 1);
        bus.id_rs1 = 4'd9;
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e) begin n_err++; $display("FAIL op2_only_wb got %h exp %h", actual(), e); end
        n_cmp++;
        if ({bus.wb_conflict, bus.fwd1_hit, bus.fwd1_data} !== {1'b0, 1'b1, 16'h2222}) begin
            n_err++; $display("FAIL op2_only_pulse got cf=%b hit=%b %h exp 0 1 2222",
                              bus.wb_conflict, bus.fwd1_hit, bus.fwd1_data);
        end
    endtask

    task automatic test_stall_flush();
        exp_t snap;
        logic [15:0] rc;
        drive(1, 1, 0, 0, 4'd6, 4'd0, 16'hBEEF, 16'h0, 16'h0, 1);
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e) begin n_err++; $display("FAIL stall_load_wb got %h exp %h", actual(), e); end
        snap = e;
        rc = bus.retire_count;
        bus.stall = 1'b1;
        drive(1, 1, 1, 1, 4'd1, 4'd2, 16'h0BAD, 16'h0BAD, 16'h0BAD, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (actual() !== snap || bus.retire_count !== rc) begin
                n_err++; $display("FAIL stall_hold%0d got %h cnt %h exp %h cnt %h", i, actual(), bus.retire_count, snap, rc);
            end
        end
        bus.flush = 1'b1;
        tick();
        n_cmp++;
        if ({bus.RegWrite, bus.WriteOP2, bus.wb_conflict, bus.retire_count} !== {3'b000, rc}) begin
            n_err++; $display("FAIL flush_stall got %b%b%b cnt %h exp 000 cnt %h",
                              bus.RegWrite, bus.WriteOP2, bus.wb_conflict, bus.retire_count, rc);
        end
        bus.flush = 1'b0; bus.stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e || bus.retire_count !== rc) begin
            n_err++; $display("FAIL after_flush got %h cnt %h exp %h cnt %h", actual(), bus.retire_count, e, rc);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 1, 0, 4'd8, 4'd9, 16'hCAFE, 16'hF00D, 16'h0, 1);
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e) begin n_err++; $display("FAIL async_pre_wb got %h exp %h", actual(), e); end
        bus.stall = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (actual() !== '0 || bus.retire_count !== 16'd0 || bus.fwd1_hit !== 1'b0) begin
            n_err++; $display("FAIL async_reset got %h cnt %h exp 0 cnt 0", actual(), bus.retire_count);
        end
        bus.stall = 1'b0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        e = q.pop_front(); n_cmp++;
        if (actual() !== e || bus.retire_count !== 16'd0) begin
            n_err++; $display("FAIL async_post got %h cnt %h exp %h cnt 0", actual(), bus.retire_count, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_rc = 16'd0;
        logic prev_v = 1'b0;
        logic v;
        logic [15:0] f1, f2;
        logic h1, h2;
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            drive(v, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom), 16'($urandom), 1);
            bus.id_rs1 = 4'($urandom_range(0, 3));
            bus.id_rs2 = 4'($urandom_range(0, 3));
            tick();
            if (prev_v) exp_rc = exp_rc + 16'd1;
            prev_v = v;
            e = q.pop_front(); n_cmp++;
            if (actual() !== e || bus.retire_count !== exp_rc) begin
                n_err++; $display("FAIL b2b%0d got %h cnt %h exp %h cnt %h", i, actual(), bus.retire_count, e, exp_rc);
            end
            h1 = (e.rw && e.rd1 == bus.id_rs1) || (e.op2 && e.rd2 == bus.id_rs1);
            h2 = (e.rw && e.rd1 == bus.id_rs2) || (e.op2 && e.rd2 == bus.id_rs2);
            f1 = (e.rw && e.rd1 == bus.id_rs1) ? e.d1 : ((e.op2 && e.rd2 == bus.id_rs1) ? e.d2 : 16'h0);
            f2 = (e.rw && e.rd1 == bus.id_rs2) ? e.d1 : ((e.op2 && e.rd2 == bus.id_rs2) ? e.d2 : 16'h0);
            n_cmp++;
            if ({bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data} !== {h1, f1, h2, f2}) begin
                n_err++; $display("FAIL b2b_fwd%0d got %b %h %b %h exp %b %h %b %h", i,
                                  bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data, h1, f1, h2, f2);
            end
        end
    endtask

    task automatic test_wrap();
        int k = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (bus.retire_count !== 16'hFFFF && k < 70000) begin
            tick();
            k++;
        end
        n_cmp++;
        if (bus.retire_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_top got %h exp ffff", bus.retire_count); end
        tick();
        n_cmp++;
        if (bus.retire_count !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h exp 0000", bus.retire_count); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.id_rs1 = 4'd0; bus.id_rs2 = 4'd0;
        test_reset();
        test_dual_write();
        test_load_select();
        test_conflict();
        test_stall_flush();
        test_async_reset();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
